// File: rtl/mealy_pkg.sv
// Shared constants for the 1011 Mealy sequence detector.
package mealy_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] PATTERN = 4'b1011;

  typedef logic [1:0] state_t;

  localparam state_t S0 = 2'b00;
  localparam state_t S1 = 2'b01;
  localparam state_t S2 = 2'b10;
  localparam state_t S3 = 2'b11;

endpackage

// File: rtl/mealy_if.sv
// Link between the pin-level top and the detector FSM.
interface mealy_if;
  import mealy_pkg::*;

  logic   step;
  logic   din;
  state_t state;
  logic   detect;

  modport master (output step, output din, input state, input detect);
  modport slave  (input step, input din, output state, output detect);

endinterface

// File: rtl/mealy_1011_fsm.sv
// Overlapping 1011 detector; detect is combinational (Mealy) on the final bit.
module mealy_1011_fsm
  import mealy_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  mealy_if.slave  fsm
);

  state_t state_q;
  state_t state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:      state_d = fsm.din ? S1 : S0;
      S1:      state_d = fsm.din ? S1 : S2;
      S2:      state_d = fsm.din ? S3 : S0;
      S3:      state_d = fsm.din ? S1 : S2;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S0;
    else if (fsm.step)
      state_q <= state_d;
  end

  assign fsm.state  = state_q;
  assign fsm.detect = (state_q == S3) & fsm.din & fsm.step;

endmodule

// File: rtl/tt_um_reuel_pandher_mealy.sv
// Tiny Tapeout wrapper: 1011 detector, wrapping match counter and pin mapping.
module tt_um_reuel_pandher_mealy
  import mealy_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  mealy_if bus ();

  assign bus.step = ena & ui_in[1];
  assign bus.din  = ui_in[0];

  // rst_n is active-high on this design despite its name.
  mealy_1011_fsm u_fsm (
    .clk (clk),
    .rst (rst_n),
    .fsm (bus.slave)
  );

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      cnt <= '0;
    else if (ena & ui_in[2])
      cnt <= '0;
    else if (bus.detect)
      cnt <= cnt + CNT_W'(1);
  end

  assign uo_out  = {cnt, 1'b0, bus.state, bus.detect};
  assign uio_out = '0;
  assign uio_oe  = '0;

  logic unused;
  assign unused = &{1'b0, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_tt_um_reuel_pandher_mealy.sv
// Bench for the 1011 detector: bit-history reference model plus directed literal checks.
module tb_tt_um_reuel_pandher_mealy;
  import mealy_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_reuel_pandher_mealy dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: history of accepted bits since reset and a 4-bit match count.
  logic [31:0] m_hist = '0;
  int          m_len  = 0;
  logic [3:0]  m_cnt  = '0;

  mealy_if exp_bus ();

  // State = longest suffix of the history that is a proper prefix of the pattern.
  function automatic logic [1:0] suffix_state(input logic [31:0] h, input int n);
    logic [3:0] p;
    p = PATTERN;
    if (n >= 3 && h[2:0] == p[3:1]) return 2'b11;
    if (n >= 2 && h[1:0] == p[3:2]) return 2'b10;
    if (n >= 1 && h[0]   == p[3])   return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    exp_bus.step   = ena & ui_in[1];
    exp_bus.din    = ui_in[0];
    exp_bus.state  = suffix_state(m_hist, m_len);
    exp_bus.detect = exp_bus.step & (m_len >= 3) & ({m_hist[2:0], ui_in[0]} == PATTERN);
  end

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_hist <= '0;
      m_len  <= 0;
      m_cnt  <= '0;
    end else begin
      if (ena & ui_in[2])
        m_cnt <= '0;
      else if (exp_bus.detect)
        m_cnt <= m_cnt + 4'd1;
      if (exp_bus.step) begin
        m_hist <= {m_hist[30:0], ui_in[0]};
        m_len  <= (m_len < 31) ? m_len + 1 : m_len;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_uo_out", uo_out, {m_cnt, 1'b0, exp_bus.state, exp_bus.detect});
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
  end

  task automatic bit_in(input logic d, input logic v, input logic c, input logic e);
    @(posedge clk);
    #1;
    ui_in  = {5'($urandom), c, v, d};
    uio_in = 8'($urandom);
    ena    = e;
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--)
      bit_in(bits[i], 1'b1, 1'b0, 1'b1);
  endtask

  task automatic lit(input string name, input logic [7:0] exp);
    #1;
    check(name, uo_out, exp);
  endtask

  task automatic async_rst();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("async_rst", uo_out, 8'h00);
    #1 rst_n = 1'b0;
    ui_in[1] = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h03;
    uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("reset_uo", uo_out, 8'h00);
    check("reset_oe", uio_oe, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ui_in = 8'h00;
    lit("post_reset", 8'h00);

    // Basic match 1,0,1,1
    bit_in(1, 1, 0, 1); lit("basic_b1", 8'h00);
    bit_in(0, 1, 0, 1); lit("basic_b2", 8'h02);
    bit_in(1, 1, 0, 1); lit("basic_b3", 8'h04);
    bit_in(1, 1, 0, 1); lit("basic_b4", 8'h07);
    bit_in(0, 0, 0, 1); lit("basic_after", 8'h12);

    // Clear, return to S0, then overlapping stream
    bit_in(0, 1, 1, 1);
    bit_in(0, 1, 0, 1);
    bit_in(0, 0, 0, 1); lit("clear", 8'h00);
    send(16'b1011011, 7);
    bit_in(0, 0, 0, 1); lit("overlap", 8'h22);

    // Non-match 1,0,0,1,1 from S0
    send(16'b00, 2);
    send(16'b10011, 5);
    bit_in(0, 0, 0, 1); lit("nomatch", 8'h22);

    // Valid gating
    send(16'b101, 3);
    repeat (3) begin
      bit_in(1, 0, 0, 1); lit("valid_hold", 8'h26);
    end
    bit_in(1, 1, 0, 1); lit("valid_det", 8'h27);

    // ena low freezes everything and ignores cnt_clr
    send(16'b01, 2);
    repeat (3) begin
      bit_in(1, 1, 1, 0); lit("ena_off", 8'h36);
    end
    bit_in(0, 0, 0, 1); lit("ena_off_after", 8'h36);

    // Clear in the same cycle as a detection
    bit_in(1, 1, 1, 1); lit("clr_det", 8'h37);
    bit_in(0, 0, 0, 1); lit("clr_det_after", 8'h02);

    // 16 matches wrap the counter
    repeat (16) send(16'b1011, 4);
    bit_in(0, 0, 0, 1); lit("wrap", 8'h02);

    // Asynchronous reset mid-sequence
    send(16'b101, 3);
    async_rst();
    bit_in(1, 1, 0, 1); lit("post_async", 8'h00);

    // Randomised traffic against the model
    repeat (3000) begin
      if ($urandom_range(99) == 0)
        async_rst();
      else
        bit_in(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(31) == 0),
               ($urandom_range(9) != 0));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
